// File: rtl/unsigned_seq_div_restoring.sv
// Sequential unsigned restoring divider: DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, with start/busy/done handshake and divide-by-zero flag.
module unsigned_seq_div_restoring #(
  parameter int DW = 12,
  parameter int VW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [VW:0]   p_q, p_d, p_nx;
  logic [DW-1:0] q_q, q_d, q_nx;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic [VW:0]   s_s, t_s;
  logic          last_s;

  assign last_s = (cnt_q == {{(CW-1){1'b0}}, 1'b1});

  // State and all datapath/output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      p_q     <= {(VW+1){1'b0}};
      q_q     <= {DW{1'b0}};
      d_q     <= {VW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      quot_q  <= {DW{1'b0}};
      rem_q   <= {VW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next state; load has priority in every state so it aborts a running division
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (divisor == {VW{1'b0}}) ? S_ZERO : S_RUN;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_RUN:   state_d = last_s ? S_DONE : S_RUN;
        S_ZERO:  state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // One restoring iteration: trial-subtract, keep the difference if non-negative
  always_comb begin
    s_s = {p_q[VW-1:0], q_q[DW-1]};
    t_s = s_s - {1'b0, d_q};
    if (!t_s[VW]) begin
      p_nx = t_s;
      q_nx = {q_q[DW-2:0], 1'b1};
    end else begin
      p_nx = s_s;
      q_nx = {q_q[DW-2:0], 1'b0};
    end
  end

  // Datapath register updates
  always_comb begin
    p_d   = p_q;
    q_d   = q_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (load) begin
      p_d   = {(VW+1){1'b0}};
      q_d   = dividend;
      d_d   = divisor;
      cnt_d = CW'(DW);
    end else if (state_q == S_RUN) begin
      p_d   = p_nx;
      q_d   = q_nx;
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs; results are written only on completion, never by an aborted run
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    busy_d = (state_d == S_RUN) || (state_d == S_ZERO);
    done_d = (state_d == S_DONE);
    if (load) begin
      dbz_d = 1'b0;
    end else if (state_q == S_ZERO) begin
      quot_d = {DW{1'b1}};
      rem_d  = {VW{1'b0}};
      dbz_d  = 1'b1;
    end else if ((state_q == S_RUN) && last_s) begin
      quot_d = q_nx;
      rem_d  = p_nx[VW-1:0];
      dbz_d  = 1'b0;
    end else begin
      dbz_d = dbz_q;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
